serial_magnitude_comparator: RTL and testbench

//   Multi-cycle magnitude comparator that scans two WIDTH-bit operands MSB-first, DIGIT bits per cycle.
//   It stops early at the first differing digit.
//   It is the sequential, MSB-first counterpart of the combinational LSB-to-MSB comparator cascade.

---
 rtl/serial_magnitude_comparator_if.sv | 29 ++
 rtl/serial_magnitude_comparator.sv | 132 +++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and data bundle for the serial magnitude comparator.
// The requester drives the operands, mode and cascade inputs and
// watches busy/done and the three one-hot result flags.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             isEqual;
  logic             isGreater;
  logic             isLess;
  logic             busy;
  logic             done;
  logic             equal;
  logic             A_greater;
  logic             A_less;

  modport master (
    output start, signed_mode, A, B, isEqual, isGreater, isLess,
    input  busy, done, equal, A_greater, A_less
  );

  modport slave (
    input  start, signed_mode, A, B, isEqual, isGreater, isLess,
    output busy, done, equal, A_greater, A_less
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first serial magnitude comparator. Scans DIGIT bits per cycle and
// stops at the first digit where the operands differ. When every digit
// matches, the result comes from the lower-order cascade inputs with
// priority isGreater > isLess, otherwise equal. isEqual is accepted on
// the bus for symmetry with the combinational cascade but never changes
// the outcome, so it is not stored.
module serial_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input logic                        clk,
  input logic                        rst_n,
  serial_magnitude_comparator_if.slave bus
);
  localparam int ND = WIDTH / DIGIT;
  localparam int CW = $clog2(ND + 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             casc_gt_q, casc_gt_d;
  logic             casc_lt_q, casc_lt_d;
  logic             equal_q, equal_d;
  logic             greater_q, greater_d;
  logic             less_q, less_d;

  logic [DIGIT-1:0] a_digit;
  logic [DIGIT-1:0] b_digit;

  // The digit under inspection is always the top of each shift register.
  assign a_digit = a_q[WIDTH-1 -: DIGIT];
  assign b_digit = b_q[WIDTH-1 -: DIGIT];

  // State and datapath registers; reset aborts any compare in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      casc_gt_q <= 1'b0;
      casc_lt_q <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
      less_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      casc_gt_q <= casc_gt_d;
      casc_lt_q <= casc_lt_d;
      equal_q   <= equal_d;
      greater_q <= greater_d;
      less_q    <= less_d;
    end
  end

  // Next-state logic: load on start, walk digits MSB-first, resolve on the
  // first difference or fall back to the cascade after the last digit.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    casc_gt_d = casc_gt_q;
    casc_lt_d = casc_lt_q;
    equal_d   = equal_q;
    greater_d = greater_q;
    less_d    = less_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Flipping both sign bits maps two's-complement order onto
          // unsigned order, so the scan itself is always unsigned.
          a_d       = {bus.A[WIDTH-1] ^ bus.signed_mode, bus.A[WIDTH-2:0]};
          b_d       = {bus.B[WIDTH-1] ^ bus.signed_mode, bus.B[WIDTH-2:0]};
          cnt_d     = CW'(ND);
          casc_gt_d = bus.isGreater;
          casc_lt_d = bus.isLess;
          equal_d   = 1'b0;
          greater_d = 1'b0;
          less_d    = 1'b0;
          state_d   = COMPARE;
        end
      end

      COMPARE: begin
        if (a_digit != b_digit) begin
          greater_d = (a_digit > b_digit);
          less_d    = (a_digit < b_digit);
          state_d   = DONE;
        end else if (cnt_q > CW'(1)) begin
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (casc_gt_q) begin
            greater_d = 1'b1;
          end else if (casc_lt_q) begin
            less_d = 1'b1;
          end else begin
            equal_d = 1'b1;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.equal     = equal_q;
  assign bus.A_greater = greater_q;
  assign bus.A_less    = less_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Testbench for serial_magnitude_comparator (WIDTH=16, DIGIT=2).
// Directed table, hand sequences for start-while-busy and mid-compare
// reset, then random operands against an arithmetic reference model.
module tb_serial_magnitude_comparator;
  localparam int WIDTH = 16;
  localparam int DIGIT = 2;
  localparam int ND    = WIDTH / DIGIT;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  serial_magnitude_comparator_if #(.WIDTH(WIDTH)) cif ();

  serial_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (cif.slave)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Flag encoding used throughout the bench: {equal, A_greater, A_less}.
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sm;
    logic             eq;
    logic             gt;
    logic             lt;
    int               expFlags;
    int               expCycle;
  } vector_t;

  vector_t table_v[$];

  function automatic int flagsNow();
    return {29'd0, cif.equal, cif.A_greater, cif.A_less};
  endfunction

  // Reference result: plain integer ordering, then cascade on a tie.
  function automatic int refFlags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic sm, input logic gt, input logic lt);
    if (sm) begin
      if ($signed(a) > $signed(b)) return 3'b010;
      if ($signed(a) < $signed(b)) return 3'b001;
    end else begin
      if (a > b) return 3'b010;
      if (a < b) return 3'b001;
    end
    if (gt) return 3'b010;
    if (lt) return 3'b001;
    return 3'b100;
  endfunction

  // Reference latency: cycle after accept in which done is seen, one more
  // than the index of the first MSB-first digit whose prefixes differ.
  function automatic int refCycle(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int k = 1; k <= ND; k++) begin
      if ((a >> (WIDTH - DIGIT * k)) != (b >> (WIDTH - DIGIT * k))) return k + 1;
    end
    return ND + 1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Runs one compare. pokeAt>0 raises start again in that cycle (busy).
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic sm, input logic eq, input logic gt,
                               input logic lt, input int pokeAt,
                               input int expFlags, input int expCycle, input string tag);
    int doneCycle;
    int pulses;
    int progressErr;
    int gotFlags;
    @(posedge clk);
    #1;
    cif.start       = 1'b1;
    cif.A           = a;
    cif.B           = b;
    cif.signed_mode = sm;
    cif.isEqual     = eq;
    cif.isGreater   = gt;
    cif.isLess      = lt;
    @(posedge clk);
    #1;
    cif.start       = 1'b0;
    cif.A           = WIDTH'($urandom);
    cif.B           = WIDTH'($urandom);
    cif.signed_mode = 1'($urandom);
    cif.isGreater   = 1'($urandom);
    cif.isLess      = 1'($urandom);
    doneCycle   = -1;
    pulses      = 0;
    progressErr = 0;
    gotFlags    = -1;
    for (int c = 1; c <= ND + 3; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      cif.start = (c == pokeAt);
      if (cif.done) begin
        pulses++;
        if (doneCycle < 0) begin
          doneCycle = c;
          gotFlags  = flagsNow();
        end
      end else if (doneCycle < 0) begin
        if (cif.busy !== 1'b1 || flagsNow() != 0) progressErr++;
      end
    end
    cif.start = 1'b0;
    checkOutput({tag, " latency"}, doneCycle, expCycle);
    checkOutput({tag, " done pulses"}, pulses, 1);
    checkOutput({tag, " flags"}, gotFlags, expFlags);
    checkOutput({tag, " in-progress busy/flags"}, progressErr, 0);
    checkOutput({tag, " idle after done"}, int'(cif.busy), 0);
    checkOutput({tag, " flags held"}, flagsNow(), expFlags);
  endtask

  initial begin
    int doneSeen;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rsm, rgt, rlt;

    vectors     = 0;
    miscompares = 0;
    rst_n           = 1'b0;
    cif.start       = 1'b0;
    cif.signed_mode = 1'b0;
    cif.A           = '0;
    cif.B           = '0;
    cif.isEqual     = 1'b0;
    cif.isGreater   = 1'b0;
    cif.isLess      = 1'b0;

    table_v.push_back('{16'hF000, 16'h7000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 2});
    table_v.push_back('{16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 2});
    table_v.push_back('{16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 2});
    table_v.push_back('{16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 9});
    table_v.push_back('{16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 9});
    table_v.push_back('{16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 9});
    table_v.push_back('{16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 9});
    table_v.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 2});
    table_v.push_back('{16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 2});
    table_v.push_back('{16'hFFFE, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 9});
    table_v.push_back('{16'h1230, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 8});
    table_v.push_back('{16'hABCD, 16'hABCD, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 9});

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", int'(cif.busy), 0);
    checkOutput("reset done", int'(cif.done), 0);
    checkOutput("reset flags", flagsNow(), 0);
    rst_n = 1'b1;

    foreach (table_v[i]) begin
      applyStimulus(table_v[i].a, table_v[i].b, table_v[i].sm, table_v[i].eq,
                    table_v[i].gt, table_v[i].lt, 0, table_v[i].expFlags,
                    table_v[i].expCycle, $sformatf("table[%0d]", i));
    end

    // Start pulsed while busy must be ignored; original result stands.
    applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'b001, 9, "start-while-busy");

    // Reset at cycle 4 of a compare: immediate clear, no done pulse.
    @(posedge clk);
    #1;
    cif.start = 1'b1;
    cif.A     = 16'h0001;
    cif.B     = 16'h0002;
    cif.signed_mode = 1'b0;
    @(posedge clk);
    #1;
    cif.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset busy", int'(cif.busy), 0);
    checkOutput("mid-reset flags", flagsNow(), 0);
    doneSeen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (cif.done) doneSeen++;
    end
    rst_n = 1'b1;
    repeat (ND + 2) begin
      @(posedge clk);
      #1;
      if (cif.done) doneSeen++;
    end
    checkOutput("mid-reset no done", doneSeen, 0);
    applyStimulus(16'hF000, 16'h7000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3'b010, 2, "after-reset");

    // Random operands, biased toward long scans and ties.
    for (int n = 0; n < 40; n++) begin
      ra  = WIDTH'($urandom);
      rsm = 1'($urandom);
      rgt = 1'($urandom);
      rlt = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = WIDTH'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      endcase
      applyStimulus(ra, rb, rsm, 1'($urandom), rgt, rlt, 0,
                    refFlags(ra, rb, rsm, rgt, rlt), refCycle(ra, rb),
                    $sformatf("random[%0d] A=%h B=%h s=%0d", n, ra, rb, rsm));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
